// File: rtl/des_sbox_feeder.sv
// DES S-box feeder: computes E(R) ^ K for one R/K pair and streams the result
// as eight 6-bit groups over a valid/ready handshake.
// Optional build macro FEEDER_BLKCNT_EN adds the blk_cnt completed-block counter.
module des_sbox_feeder #(
  parameter bit          REV_ORDER = 1'b0,
  parameter int unsigned KEY_W     = 48
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_r,
  input  logic [KEY_W-1:0] in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_grp,
  output logic [2:0]       out_idx,
  output logic             out_last
`ifdef FEEDER_BLKCNT_EN
  ,
  output logic [15:0]      blk_cnt
`endif
);

  typedef enum logic {StIdle, StSend} state_e;

  localparam logic [2:0] CntFirst = REV_ORDER ? 3'd7 : 3'd0;
  localparam logic [2:0] CntLast  = REV_ORDER ? 3'd0 : 3'd7;

  state_e      state_q, state_d;
  logic [47:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [47:0] exp_r;
  logic [5:0]  grp_sel;
  logic        last_grp;
  logic        last_hs;

  // E expansion: group i (0-based) takes DES bits 4i..4i+5 with wrap, group 0 at [47:42].
  // DES bit n sits at in_r[32-n]; (64-n)%32 folds n=0 onto bit 32 and n=33 onto bit 1.
  always_comb begin
    exp_r = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 6; j++) begin
        exp_r[47 - 6*i - j] = in_r[(64 - 4*i - j) % 32];
      end
    end
  end

  // Select the registered group addressed by the counter.
  always_comb begin
    grp_sel = '0;
    case (cnt_q)
      3'd0:    grp_sel = data_q[47:42];
      3'd1:    grp_sel = data_q[41:36];
      3'd2:    grp_sel = data_q[35:30];
      3'd3:    grp_sel = data_q[29:24];
      3'd4:    grp_sel = data_q[23:18];
      3'd5:    grp_sel = data_q[17:12];
      3'd6:    grp_sel = data_q[11:6];
      default: grp_sel = data_q[5:0];
    endcase
  end

  assign last_grp = (cnt_q == CntLast);

  // Next-state and handshake outputs; outputs idle at zero so reset forces them low.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_grp   = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    last_hs   = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = exp_r ^ in_k;
          cnt_d   = CntFirst;
          state_d = StSend;
        end
      end
      StSend: begin
        out_valid = 1'b1;
        out_grp   = grp_sel;
        out_idx   = cnt_q;
        out_last  = last_grp;
        // A new pair can only be taken as the final group leaves.
        in_ready  = last_grp & out_ready;
        if (out_ready) begin
          if (!last_grp) begin
            cnt_d = REV_ORDER ? cnt_q - 3'd1 : cnt_q + 3'd1;
          end else begin
            last_hs = 1'b1;
            if (in_valid) begin
              data_d = exp_r ^ in_k;
              cnt_d  = CntFirst;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, data and counter registers.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FEEDER_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  // Count completed blocks; wraps naturally at 16 bits.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (last_hs) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_des_sbox_feeder.sv
// Bench for des_sbox_feeder: both group orders side by side, scored against a
// DES-numbered expansion model and a block queue.
module tb_des_sbox_feeder;

  logic        ck = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_r;
  logic [47:0] in_k;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [5:0]  out_grp0, out_grp1;
  logic [2:0]  out_idx0, out_idx1;
  logic        out_last0, out_last1;
`ifdef FEEDER_BLKCNT_EN
  logic [15:0] blk_cnt0, blk_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit rdy_rand = 1'b0;

  typedef struct packed {
    logic [31:0] r;
    logic [47:0] k;
  } blk_t;

  blk_t        blkq[$];
  int          pos = 0;
  logic [15:0] mdl_blks = '0;
  logic        busy, exp_ir;

  always #5 ck = ~ck;

  des_sbox_feeder #(.REV_ORDER(1'b0), .KEY_W(48)) u_fwd (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_r(in_r), .in_k(in_k),
    .out_valid(out_valid0), .out_ready(out_ready), .out_grp(out_grp0), .out_idx(out_idx0),
    .out_last(out_last0)
`ifdef FEEDER_BLKCNT_EN
    , .blk_cnt(blk_cnt0)
`endif
  );

  des_sbox_feeder #(.REV_ORDER(1'b1), .KEY_W(48)) u_rev (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_r(in_r), .in_k(in_k),
    .out_valid(out_valid1), .out_ready(out_ready), .out_grp(out_grp1), .out_idx(out_idx1),
    .out_last(out_last1)
`ifdef FEEDER_BLKCNT_EN
    , .blk_cnt(blk_cnt1)
`endif
  );

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // S-box s (1..8): DES bits 4s-4..4s+1 of R with wrap, xored with K bits 6s-5..6s.
  function automatic logic [5:0] model_grp(input logic [31:0] r, input logic [47:0] k,
                                           input int s);
    logic [5:0] g;
    int n;
    for (int j = 0; j < 6; j++) begin
      n = 4*s - 4 + j;
      if (n < 1) n += 32;
      if (n > 32) n -= 32;
      g[5-j] = r[32-n] ^ k[48 - (6*s - 5 + j)];
    end
    return g;
  endfunction

  task automatic chk_out(input string tag, input bit rev, input logic v, input logic [5:0] g,
                         input logic [2:0] idx, input logic last, input logic ir);
    int s;
    check_eq({tag, "_in_ready"}, ir, exp_ir);
    check_eq({tag, "_valid"}, v, busy);
    if (busy) begin
      s = rev ? 8 - pos : pos + 1;
      check_eq({tag, "_grp"}, g, model_grp(blkq[0].r, blkq[0].k, s));
      check_eq({tag, "_idx"}, idx, s - 1);
      check_eq({tag, "_last"}, last, pos == 7);
    end
  endtask

  task automatic chk_reset(input string tag, input logic v, input logic [5:0] g,
                           input logic [2:0] idx, input logic last, input logic ir);
    check_eq({tag, "_rst_valid"}, v, 0);
    check_eq({tag, "_rst_grp"}, g, 0);
    check_eq({tag, "_rst_idx"}, idx, 0);
    check_eq({tag, "_rst_last"}, last, 0);
    check_eq({tag, "_rst_in_ready"}, ir, 1);
  endtask

  // Scoreboard on the falling edge: inputs and outputs are settled, next rising edge commits.
  always @(negedge ck) begin
    if (rst) begin
      chk_reset("fwd", out_valid0, out_grp0, out_idx0, out_last0, in_ready0);
      chk_reset("rev", out_valid1, out_grp1, out_idx1, out_last1, in_ready1);
`ifdef FEEDER_BLKCNT_EN
      check_eq("fwd_rst_blk_cnt", blk_cnt0, 0);
      check_eq("rev_rst_blk_cnt", blk_cnt1, 0);
`endif
      blkq.delete();
      pos = 0;
      mdl_blks = '0;
    end else begin
      busy   = (blkq.size() != 0);
      exp_ir = !busy || (pos == 7 && out_ready);
      chk_out("fwd", 1'b0, out_valid0, out_grp0, out_idx0, out_last0, in_ready0);
      chk_out("rev", 1'b1, out_valid1, out_grp1, out_idx1, out_last1, in_ready1);
`ifdef FEEDER_BLKCNT_EN
      check_eq("fwd_blk_cnt", blk_cnt0, mdl_blks);
      check_eq("rev_blk_cnt", blk_cnt1, mdl_blks);
`endif
      if (busy && out_ready) begin
        pos++;
        if (pos == 8) begin
          void'(blkq.pop_front());
          pos = 0;
          mdl_blks++;
        end
      end
      if (in_valid && exp_ir) blkq.push_back('{r: in_r, k: in_k});
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present a pair and hold it until the feeder takes it.
  task automatic send(input logic [31:0] r, input logic [47:0] k);
    int n = 0;
    in_valid = 1'b1;
    in_r = r;
    in_k = k;
    @(negedge ck);
    while (!in_ready0 && n < 200) begin
      tick();
      @(negedge ck);
      n++;
    end
    if (n >= 200) check_eq("send_timeout_in_ready", in_ready0, 1);
    tick();
    in_valid = 1'b0;
    in_r = $urandom;
    in_k = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
  endtask

  task automatic drain();
    int n = 0;
    while (blkq.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check_eq("drain_fwd_valid", out_valid0, 0);
    check_eq("drain_rev_valid", out_valid1, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_r = '0;
    in_k = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge ck);
    #1 rst = 1'b0;

    // Directed patterns: zero, all ones from R, all ones from K, wrap bits.
    send(32'h0, 48'h0);
    drain();
    send(32'hFFFF_FFFF, 48'h0);
    drain();
    send(32'h0, 48'hFFFF_FFFF_FFFF);
    drain();
    send(32'h8000_0001, 48'h0);
    drain();

    // Backpressure: stall four cycles while group index 2 is presented.
    out_ready = 1'b0;
    send(32'h0, 48'h0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    repeat (4) begin
      tick();
      check_eq("stall_idx", out_idx0, 2);
      check_eq("stall_valid", out_valid0, 1);
    end
    out_ready = 1'b1;
    drain();

    // Back-to-back: in_valid stays high across the two handshakes.
    send($urandom, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    send($urandom, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    drain();

    // Reset while index 4 is on the output.
    send($urandom, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    repeat (4) tick();
    check_eq("pre_rst_idx", out_idx0, 4);
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid", out_valid0, 0);
    check_eq("rst_async_in_ready", in_ready0, 1);
    tick();
    rst = 1'b0;
    send($urandom, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    drain();

    // Random traffic with random sink stalls and random input gaps.
    rdy_rand = 1'b1;
    for (int b = 0; b < 40; b++) begin
      send($urandom, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    rdy_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
